// File: rtl/o2_pkg.sv
// Shared definitions for the trainer-CPU host tooling: frame constants and loader states.
package o2_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         IMEM_DEPTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CSUM
    } loader_state_t;

    // A length byte is usable only if it names at least one byte and fits the memory.
    function automatic logic len_valid(input logic [7:0] n, input int max_len);
        return (n != 8'd0) && (int'(n) <= max_len);
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle counter: counts while run is high, saturates at TIMEOUT, and flags expiry.
module frame_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (run && (count_reg != W'(TIMEOUT))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == W'(TIMEOUT));

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the trainer CPU instruction memory; holds the CPU in
// reset until a frame with a matching checksum has been written.
module prog_loader
    import o2_pkg::*;
#(
    parameter int TIMEOUT = 1000,
    parameter int MAX_LEN = IMEM_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [3:0] instr_addr,
    output logic [7:0] instr_data,
    output logic       instr_we,
    output logic       cpu_rst,
    output logic       busy,
    output logic       done,
    output logic       err
);

    loader_state_t state_reg, state_next;

    logic [4:0] len_reg, len_next;
    logic [4:0] idx_reg, idx_next;
    logic [7:0] sum_reg, sum_next;

    logic       rx_ready_reg, rx_ready_next;
    logic [3:0] instr_addr_reg, instr_addr_next;
    logic [7:0] instr_data_reg, instr_data_next;
    logic       instr_we_reg, instr_we_next;
    logic       cpu_rst_reg, cpu_rst_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       err_reg, err_next;

    logic accept;
    logic timer_run;
    logic timer_clear;
    logic expired;

    assign accept      = rx_valid && rx_ready_reg;
    assign timer_run   = (state_reg == LEN) || (state_reg == DATA) || (state_reg == CSUM);
    assign timer_clear = accept || (state_reg == IDLE);

    frame_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .run     (timer_run),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && (rx_data == SYNC_BYTE)) state_next = LEN;
            end
            LEN: begin
                if (accept)       state_next = len_valid(rx_data, MAX_LEN) ? DATA : IDLE;
                else if (expired) state_next = IDLE;
            end
            DATA: begin
                if (accept)       state_next = WRITE;
                else if (expired) state_next = IDLE;
            end
            WRITE: begin
                state_next = (5'(idx_reg + 5'd1) == len_reg) ? CSUM : DATA;
            end
            CSUM: begin
                if (accept || expired) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Every output is computed one cycle ahead so that the registered copy lines up
    // with the state it belongs to (e.g. instr_we is high exactly during WRITE).
    always_comb begin
        len_next        = len_reg;
        idx_next        = idx_reg;
        sum_next        = sum_reg;
        instr_addr_next = instr_addr_reg;
        instr_data_next = instr_data_reg;
        cpu_rst_next    = cpu_rst_reg;
        err_next        = err_reg;
        instr_we_next   = 1'b0;
        done_next       = 1'b0;
        rx_ready_next   = (state_next != WRITE);
        busy_next       = (state_next != IDLE);
        case (state_reg)
            IDLE: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    cpu_rst_next = 1'b1;
                    err_next     = 1'b0;
                end
            end
            LEN: begin
                if (accept) begin
                    if (len_valid(rx_data, MAX_LEN)) begin
                        len_next        = rx_data[4:0];
                        idx_next        = 5'd0;
                        sum_next        = 8'd0;
                        instr_addr_next = 4'd0;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (expired) begin
                    err_next = 1'b1;
                end
            end
            DATA: begin
                if (accept) begin
                    instr_data_next = rx_data;
                    sum_next        = sum_reg + rx_data;
                    instr_addr_next = idx_reg[3:0];
                    instr_we_next   = 1'b1;
                end else if (expired) begin
                    err_next = 1'b1;
                end
            end
            WRITE: begin
                idx_next = 5'(idx_reg + 5'd1);
            end
            CSUM: begin
                if (accept) begin
                    if (rx_data == sum_reg) begin
                        done_next    = 1'b1;
                        cpu_rst_next = 1'b0;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (expired) begin
                    err_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len_reg        <= 5'd0;
            idx_reg        <= 5'd0;
            sum_reg        <= 8'd0;
            rx_ready_reg   <= 1'b0;
            instr_addr_reg <= 4'd0;
            instr_data_reg <= 8'd0;
            instr_we_reg   <= 1'b0;
            cpu_rst_reg    <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            len_reg        <= len_next;
            idx_reg        <= idx_next;
            sum_reg        <= sum_next;
            rx_ready_reg   <= rx_ready_next;
            instr_addr_reg <= instr_addr_next;
            instr_data_reg <= instr_data_next;
            instr_we_reg   <= instr_we_next;
            cpu_rst_reg    <= cpu_rst_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    assign rx_ready   = rx_ready_reg;
    assign instr_addr = instr_addr_reg;
    assign instr_data = instr_data_reg;
    assign instr_we   = instr_we_reg;
    assign cpu_rst    = cpu_rst_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;

endmodule
